// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester block RAM arbiter.
package ram_arb_pkg;

  localparam int NUM_REQ    = 2;
  localparam int RD_LATENCY = 1;

  // Identifies a requester: 0 = CPU bus interface, 1 = loader/DMA path.
  typedef logic req_id_t;

  function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter. Round-robin with a pointer register when RAM_ARB_RR_EN
// is defined, otherwise fixed priority with requester 0 winning conflicts.
module rr_arb2
  import ram_arb_pkg::*;
(
`ifdef RAM_ARB_RR_EN
  input  logic               clka,
  input  logic               rst,
`endif
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output req_id_t            gnt_id
);

  req_id_t pref;

`ifdef RAM_ARB_RR_EN
  req_id_t ptr_q, ptr_d;

  // Only a contested grant hands priority to the other requester.
  always_comb begin
    ptr_d = ptr_q;
    if (&req) ptr_d = ~ptr_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

  assign pref = ptr_q;
`else
  assign pref = 1'b0;
`endif

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    gnt    = '0;
    gnt_id = 1'b0;
    unique case (req)
      2'b01: begin gnt = 2'b01;           gnt_id = 1'b0; end
      2'b10: begin gnt = 2'b10;           gnt_id = 1'b1; end
      2'b11: begin gnt = id_onehot(pref); gnt_id = pref; end
      default: ;
    endcase
  end

endmodule

// File: rtl/block_ram_arbiter.sv
// Shares a dual-port block RAM between two requesters, arbitrating the write
// and read ports independently. RAM_ARB_RR_EN selects round-robin arbitration.
module block_ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clka,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [31:0]           wdata0,
  input  logic [31:0]           wdata1,
  input  logic [3:0]            be0,
  input  logic [3:0]            be1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [31:0]           rdata,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [31:0]           ram_dina,
  output logic [3:0]            ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [31:0]           ram_doutb
);

  logic [NUM_REQ-1:0] wr_req, rd_req, wr_gnt, rd_gnt;
  req_id_t            wr_id, rd_id;
  logic               rd_pend_q, rd_pend_d;
  req_id_t            rd_own_q, rd_own_d;

  // Requests are masked during reset so no grant or RAM enable can escape.
  assign wr_req = rst ? '0 : {req1 &  we1, req0 &  we0};
  assign rd_req = rst ? '0 : {req1 & ~we1, req0 & ~we0};

  rr_arb2 u_wr_arb (
`ifdef RAM_ARB_RR_EN
    .clka   (clka),
    .rst    (rst),
`endif
    .req    (wr_req),
    .gnt    (wr_gnt),
    .gnt_id (wr_id)
  );

  rr_arb2 u_rd_arb (
`ifdef RAM_ARB_RR_EN
    .clka   (clka),
    .rst    (rst),
`endif
    .req    (rd_req),
    .gnt    (rd_gnt),
    .gnt_id (rd_id)
  );

  assign gnt0 = wr_gnt[0] | rd_gnt[0];
  assign gnt1 = wr_gnt[1] | rd_gnt[1];

  always_comb begin
    ram_addra = '0;
    ram_dina  = '0;
    ram_wea   = '0;
    ram_addrb = '0;
    rd_pend_d = |rd_gnt;
    rd_own_d  = rd_id;
    if (|wr_gnt) begin
      ram_addra = wr_id ? addr1  : addr0;
      ram_dina  = wr_id ? wdata1 : wdata0;
      ram_wea   = wr_id ? be1    : be0;
    end
    if (|rd_gnt) ram_addrb = rd_id ? addr1 : addr0;
  end

  // Clearing rd_pend on reset drops any read in flight.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      rd_own_q  <= 1'b0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_own_q  <= rd_own_d;
    end
  end

  assign rvalid0 = rd_pend_q & ~rd_own_q;
  assign rvalid1 = rd_pend_q &  rd_own_q;
  assign rdata   = rd_pend_q ? ram_doutb : '0;

endmodule

// File: tb/tb_block_ram_arbiter.sv
// Self-checking bench for block_ram_arbiter with a behavioural read-first RAM
// and a read-data scoreboard; expectations follow RAM_ARB_RR_EN.
module tb_block_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int AW = 14;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clka = 1'b0;
  logic rst;
  always #5 clka = ~clka;

  logic          r_req   [2];
  logic          r_we    [2];
  logic [AW-1:0] r_addr  [2];
  logic [31:0]   r_wdata [2];
  logic [3:0]    r_be    [2];

  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0]   rdata, ram_dina, ram_doutb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [3:0]    ram_wea;

  block_ram_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clka      (clka),
    .rst       (rst),
    .req0      (r_req[0]),
    .req1      (r_req[1]),
    .we0       (r_we[0]),
    .we1       (r_we[1]),
    .addr0     (r_addr[0]),
    .addr1     (r_addr[1]),
    .wdata0    (r_wdata[0]),
    .wdata1    (r_wdata[1]),
    .be0       (r_be[0]),
    .be1       (r_be[1]),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata     (rdata),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_wea   (ram_wea),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb)
  );

  // Read-first RAM: the registered read sees the word from before this edge's write.
  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] exp_mem [0:(1<<AW)-1];
  always @(posedge clka) begin
    ram_doutb <= mem[ram_addrb];
    for (int b = 0; b < 4; b++)
      if (ram_wea[b]) mem[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
  end

  typedef struct {
    logic        own;
    logic [31:0] data;
    int          due;
  } rd_exp_t;
  rd_exp_t sb[$];

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic set_rd(input int i, input int a);
    r_req[i]   = 1'b1;
    r_we[i]    = 1'b0;
    r_addr[i]  = a[AW-1:0];
    r_wdata[i] = '0;
    r_be[i]    = 4'hF;
  endtask

  task automatic set_wr(input int i, input int a, input logic [31:0] d, input logic [3:0] be);
    r_req[i]   = 1'b1;
    r_we[i]    = 1'b1;
    r_addr[i]  = a[AW-1:0];
    r_wdata[i] = d;
    r_be[i]    = be;
  endtask

  // One clock cycle: check read return and grants, update the model, retire grants.
  task automatic step(input logic e0, input logic e1, input string tag);
    logic    e[2];
    logic    any_wr;
    rd_exp_t x;
    e[0] = e0;
    e[1] = e1;
    @(negedge clka);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      x = sb.pop_front();
      check({tag, "/rvalid0"}, {31'b0, rvalid0}, {31'b0, ~x.own});
      check({tag, "/rvalid1"}, {31'b0, rvalid1}, {31'b0,  x.own});
      check({tag, "/rdata"},   rdata, x.data);
    end else begin
      check({tag, "/rvalid0_idle"}, {31'b0, rvalid0}, 32'd0);
      check({tag, "/rvalid1_idle"}, {31'b0, rvalid1}, 32'd0);
    end
    check({tag, "/gnt0"}, {31'b0, gnt0}, {31'b0, e0});
    check({tag, "/gnt1"}, {31'b0, gnt1}, {31'b0, e1});
    for (int i = 0; i < 2; i++)
      if (e[i] && !r_we[i]) begin
        check({tag, "/ram_addrb"}, {18'b0, ram_addrb}, {18'b0, r_addr[i]});
        sb.push_back('{own: 1'(i), data: exp_mem[r_addr[i]], due: cyc + RD_LATENCY});
      end
    any_wr = 1'b0;
    for (int i = 0; i < 2; i++)
      if (e[i] && r_we[i]) begin
        any_wr = 1'b1;
        check({tag, "/ram_wea"},   {28'b0, ram_wea},   {28'b0, r_be[i]});
        check({tag, "/ram_addra"}, {18'b0, ram_addra}, {18'b0, r_addr[i]});
        check({tag, "/ram_dina"},  ram_dina, r_wdata[i]);
        for (int b = 0; b < 4; b++)
          if (r_be[i][b]) exp_mem[r_addr[i]][8*b +: 8] = r_wdata[i][8*b +: 8];
      end
    if (!any_wr) check({tag, "/ram_wea_idle"}, {28'b0, ram_wea}, 32'd0);
    @(posedge clka);
    cyc++;
    #1;
    for (int i = 0; i < 2; i++)
      if (e[i]) r_req[i] = 1'b0;
  endtask

  initial begin
    logic e0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = 32'hA500_0000 ^ (i * 32'h0000_9E37);
      exp_mem[i] = mem[i];
    end
    mem[16'h20] = 32'hAAAA_AAAA; exp_mem[16'h20] = 32'hAAAA_AAAA;
    mem[16'h30] = 32'hFFFF_FFFF; exp_mem[16'h30] = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0; r_be[i] = '0;
    end

    // Reset holds off grants even with requests present.
    rst = 1'b1;
    set_rd(0, 'h10);
    set_wr(1, 'h11, 32'h0BAD_0BAD, 4'hF);
    step(1'b0, 1'b0, "reset");
    check("reset/rdata", rdata, 32'd0);
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
    rst = 1'b0;
    step(1'b0, 1'b0, "idle");

    // Write then read back through requester 0.
    set_wr(0, 'h10, 32'hDEAD_BEEF, 4'hF);
    step(1'b1, 1'b0, "wr10");
    set_rd(0, 'h10);
    step(1'b1, 1'b0, "rd10");
    step(1'b0, 1'b0, "rd10_ret");

    // Write and read of the same word in one cycle: the read sees the old data.
    set_wr(0, 'h20, 32'h1122_3344, 4'hF);
    set_rd(1, 'h20);
    step(1'b1, 1'b1, "wr_rd_same");
    set_rd(0, 'h20);
    step(1'b1, 1'b0, "rd20");
    step(1'b0, 1'b0, "rd20_ret");

    // Single byte lane write, then readback.
    set_wr(0, 'h30, 32'h00CC_0000, 4'b0100);
    step(1'b1, 1'b0, "be_wr");
    set_rd(1, 'h30);
    step(1'b0, 1'b1, "be_rd");
    step(1'b0, 1'b0, "be_ret");

    // All-zero byte enables are granted but leave the word untouched.
    set_wr(1, 'h20, 32'h1234_5678, 4'b0000);
    step(1'b0, 1'b1, "be0_wr");
    set_rd(0, 'h20);
    step(1'b1, 1'b0, "be0_rd");
    step(1'b0, 1'b0, "be0_ret");

    // Continuous read conflict.
    for (int k = 0; k < 8; k++) begin
      if (!r_req[0]) set_rd(0, 'h100 + k);
      if (!r_req[1]) set_rd(1, 'h200 + k);
      e0 = RR ? (k % 2 == 0) : 1'b1;
      step(e0, ~e0, $sformatf("rdc%0d", k));
    end
    step(r_req[0], r_req[1], "rdc_drain");
    step(1'b0, 1'b0, "rdc_ret");

    // Continuous write conflict.
    for (int k = 0; k < 8; k++) begin
      if (!r_req[0]) set_wr(0, 'h300 + k, $urandom, 4'hF);
      if (!r_req[1]) set_wr(1, 'h380 + k, $urandom, 4'hF);
      e0 = RR ? (k % 2 == 0) : 1'b1;
      step(e0, ~e0, $sformatf("wrc%0d", k));
    end
    step(r_req[0], r_req[1], "wrc_drain");
    set_rd(0, 'h300);
    step(1'b1, 1'b0, "wrc_rb0");
    set_rd(0, 'h380);
    step(1'b1, 1'b0, "wrc_rb1");
    step(1'b0, 1'b0, "wrc_ret");

    // Reset with a read in flight and requester 1 still waiting.
    set_rd(0, 'h40);
    set_rd(1, 'h41);
    step(1'b1, 1'b0, "pre_rst");
    rst = 1'b1;
    sb.delete();
    set_rd(0, 'h42);
    step(1'b0, 1'b0, "in_rst0");
    step(1'b0, 1'b0, "in_rst1");
    rst = 1'b0;
    step(1'b1, 1'b0, "post_rst_c");
    step(1'b0, 1'b1, "post_rst_r1");
    step(1'b0, 1'b0, "post_rst_ret");
    step(1'b0, 1'b0, "final_idle");
    check("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/block_ram_arbiter.md
# block_ram_arbiter

Two-requester arbiter in front of the dual-port block RAM (32-bit words, separate write and read ports, one-cycle registered read). It lets the CPU bus interface (requester 0) and the loader/DMA path (requester 1) share the RAM. It arbitrates the write port and the read port independently, so a write from one requester and a read from the other complete in the same cycle. It also returns read data to the requester that issued the read.

## Interface
Parameters:
- ADDR_WIDTH, 14, word-address width; matches the RAM.

Ports:
- clka  in  1  clock, shared with the RAM.
- rst  in  1  asynchronous reset, active-high.
- req0 / req1  in  1  request valid; held until granted.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_WIDTH  word address.
- wdata0 / wdata1  in  32  write data.
- be0 / be1  in  4  byte enables; ignored for reads.
- gnt0 / gnt1  out  1  request accepted this cycle (combinational).
- rvalid0 / rvalid1  out  1  read data valid for that requester.
- rdata  out  32  read data; qualified by rvalid0/rvalid1.
- ram_addra  out  ADDR_WIDTH  RAM write address.
- ram_dina  out  32  RAM write data.
- ram_wea  out  4  RAM byte write enables.
- ram_addrb  out  ADDR_WIDTH  RAM read address.
- ram_doutb  in  32  RAM read data.

## Operation
- Write port and read port are arbitrated independently. Only two reads, or two writes, in the same cycle conflict.
- No conflict: each requester is granted in the cycle it asserts req.
- Conflict: one requester is granted; the loser keeps req and its payload stable and is granted later.
- Round-robin pointer per port (wr_ptr, rd_ptr), reset to 0 so requester 0 wins the first conflict.
  - On a conflicted grant, the pointer moves to the other requester.
  - An unconflicted grant leaves the pointer unchanged.
- Write grant:
  - ram_addra = winner addr, ram_dina = winner wdata, ram_wea = winner be.
  - be = 4'b0000 is granted and consumed; no RAM change.
- Read grant:
  - ram_addrb = winner addr.
  - Owner tag registered as rd_own (1 bit) and rd_pend = 1.
- Next cycle: rvalid[rd_own] = 1, rdata = ram_doutb.
- Idle ports: ram_wea = 0; ram_addra, ram_addrb, ram_dina = 0.
- Read and write to the same address in the same cycle: read returns the old word (read-first). No forwarding.
- Reads are fully pipelined: one grant per cycle on the read port, back-to-back rvalid with no bubble.

## Timing
- Grant path is combinational: req/we/addr to gnt and to the RAM ports in the same cycle.
- Read latency is exactly 1 cycle from gnt to rvalid.
- Write takes effect at the granting clka edge.
- Reset values:
  - gnt0/1 = 0 and RAM enables = 0 while rst is high.
  - rvalid0/1 = 0, rdata = 0, rd_pend = 0, wr_ptr = rd_ptr = 0.
- Reset asserted with a read in flight: the pending rvalid is dropped and never appears after reset release. RAM contents are unaffected.
- Starvation bound: under continuous conflict, each requester is granted at least every 2nd cycle (round-robin build).

## Configuration
- RAM_ARB_RR_EN defined: round-robin per port as above.
- RAM_ARB_RR_EN undefined: fixed priority, requester 0 always wins conflicts. Pointers are removed and requester 1 can starve.
- Read latency and all other behaviour are identical in both builds.

## Structure
- Package ram_arb_pkg holds:
  - NUM_REQ = 2
  - RD_LATENCY = 1
  - the requester-ID type (1 bit) used for the pointers and rd_own.
- Sub-module rr_arb2: two-input arbiter with its pointer register; fixed-priority when RAM_ARB_RR_EN is undefined. Instanced once for the write port and once for the read port.

## Test plan
- Reset, then req0 write addr 0x0010, wdata 0xDEADBEEF, be 4'hF. Then req0 read 0x0010 → gnt0 same cycle; rvalid0 one cycle later with rdata 0xDEADBEEF.
- Same cycle: req0 write 0x0020 = 0x11223344 and req1 read 0x0020 (old 0xAAAAAAAA) → gnt0 = gnt1 = 1; rvalid1 with 0xAAAAAAAA; a later read returns 0x11223344.
- Both requesters read continuously, 8 cycles, distinct addresses (RR build) → grants alternate 0,1,0,1…; rvalid alternates with correct per-owner data and no bubble.
- Both write continuously, fixed-priority build → gnt0 every cycle, gnt1 never; after req0 drops, gnt1 in the next cycle.
- Byte enable 4'b0100 with wdata 0x00CC0000 over 0xFFFFFFFF → readback 0xFFCCFFFF.
- Grant a read, assert rst in the following cycle → rvalid0/1 stay 0 through and after reset; the first conflict after release goes to requester 0.
